// File: rtl/noc_rr_arbiter_n.sv
// noc_rr_arbiter_n: parametrised round-robin arbiter for one NoC output port.
// Registered one-hot grant, binary grant index and grant-valid; xfer_o is a
// single AND of registered grant state, the granted request and ready_i.
// Optional feature macro: NOC_RR_ARB_PACKET_LOCK_EN
//   defined   -> grant held from head flit to tail flit (packet lock)
//   undefined -> every transfer releases (flit-level round-robin), and a
//                granted input that withdraws its request loses the port.
module noc_rr_arbiter_n #(
   parameter int N    = 5,
   parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req_i,
   input  logic [N-1:0]    tail_i,
   input  logic            ready_i,
   output logic [N-1:0]    grant_o,
   output logic [IDXW-1:0] grant_idx_o,
   output logic            grant_valid_o,
   output logic            xfer_o
);

   typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t          state_reg, state_next;
   logic [IDXW-1:0] ptr_reg, ptr_next;
   logic [IDXW-1:0] idx_reg, idx_next;
   logic            valid_reg, valid_next;
   logic [N-1:0]    grant_reg, grant_next;

   logic [IDXW-1:0] ptr_release;
   logic            found_cur, found_rel;
   logic [IDXW-1:0] win_cur, win_rel;
   logic            release_cyc;

   // First set bit of r scanning p, p+1, ..., N-1, 0, ..., p-1.
   // Scanning from the far end down lets the nearest candidate overwrite.
   function automatic logic [IDXW:0] pick_winner(input logic [N-1:0]    r,
                                                  input logic [IDXW-1:0] p);
      logic            found;
      logic [IDXW-1:0] idx;
      logic [IDXW-1:0] jj;
      int              j;
      found = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(p) + k;
         if (j >= N) j = j - N;
         jj = j[IDXW-1:0];
         if (r[jj]) begin
            found = 1'b1;
            idx   = jj;
         end
      end
      return {found, idx};
   endfunction

   // Pointer after a release: the just-served input drops to lowest priority.
   assign ptr_release = (idx_reg == IDXW'(N - 1)) ? '0 : idx_reg + 1'b1;

   // Two candidate winners: one for the current pointer, one for the
   // post-release pointer, so a release can hand over with no bubble.
   assign {found_cur, win_cur} = pick_winner(req_i, ptr_reg);
   assign {found_rel, win_rel} = pick_winner(req_i, ptr_release);

   assign xfer_o = valid_reg & req_i[idx_reg] & ready_i;

`ifdef NOC_RR_ARB_PACKET_LOCK_EN
   assign release_cyc = xfer_o & tail_i[idx_reg];
`else
   // Tail flags carry no meaning when every flit releases the port.
   logic tail_unused;
   assign tail_unused = ^tail_i;
   assign release_cyc = xfer_o;
`endif

   // Next-state logic: acquire from IDLE, hold or hand over while LOCKED.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      idx_next   = idx_reg;
      valid_next = valid_reg;
      case (state_reg)
         IDLE: begin
            if (found_cur) begin
               state_next = LOCKED;
               idx_next   = win_cur;
               valid_next = 1'b1;
            end
         end
         LOCKED: begin
            if (release_cyc) begin
               ptr_next = ptr_release;
               if (found_rel) begin
                  idx_next = win_rel;
               end else begin
                  state_next = IDLE;
                  idx_next   = '0;
                  valid_next = 1'b0;
               end
            end
`ifndef NOC_RR_ARB_PACKET_LOCK_EN
            // Withdrawn request: re-arbitrate without moving the pointer.
            else if (!req_i[idx_reg]) begin
               if (found_cur) begin
                  idx_next = win_cur;
               end else begin
                  state_next = IDLE;
                  idx_next   = '0;
                  valid_next = 1'b0;
               end
            end
`endif
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
            valid_next = 1'b0;
         end
      endcase
   end

   // One-hot decode of the next grant index, all-zero when going idle.
   for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign grant_next[gi] = valid_next & (idx_next == IDXW'(gi));
   end

   // State, pointer and grant registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         idx_reg   <= '0;
         valid_reg <= 1'b0;
         grant_reg <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         idx_reg   <= idx_next;
         valid_reg <= valid_next;
         grant_reg <= grant_next;
      end
   end

   assign grant_o       = grant_reg;
   assign grant_idx_o   = idx_reg;
   assign grant_valid_o = valid_reg;

endmodule

// File: tb/tb_noc_rr_arbiter_n.sv
// Bench for noc_rr_arbiter_n: an N=5 and an N=4 instance share clock and reset.
// A behavioural reference model pushes the expected registered outputs into
// per-instance queues each cycle; they are popped and compared after the edge.
// Directed constants cover the listed scenarios for the selected build mode.
module tb_noc_rr_arbiter_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [4:0] req5, tail5, g5;
   logic [2:0] idx5;
   logic       ready5, v5, x5;
   logic [3:0] req4, tail4, g4;
   logic [1:0] idx4;
   logic       ready4, v4, x4;

   noc_rr_arbiter_n #(.N(5)) u5 (
      .clk(clk), .reset(reset), .req_i(req5), .tail_i(tail5), .ready_i(ready5),
      .grant_o(g5), .grant_idx_o(idx5), .grant_valid_o(v5), .xfer_o(x5)
   );

   noc_rr_arbiter_n #(.N(4)) u4 (
      .clk(clk), .reset(reset), .req_i(req4), .tail_i(tail4), .ready_i(ready4),
      .grant_o(g4), .grant_idx_o(idx4), .grant_valid_o(v4), .xfer_o(x4)
   );

`ifdef NOC_RR_ARB_PACKET_LOCK_EN
   localparam bit LOCK_MODE = 1'b1;
   logic [4:0] exp_b [3] = '{5'b00001, 5'b00001, 5'b01000};
   logic [3:0] exp_e [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000};
   logic [3:0] exp_f [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
   localparam bit LOCK_MODE = 1'b0;
   logic [4:0] exp_b [3] = '{5'b01000, 5'b00001, 5'b01000};
   logic [3:0] exp_e [4] = '{4'b1000, 4'b0000, 4'b0000, 4'b0001};
   logic [3:0] exp_f [6] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
   int exp_c [6] = '{0, 1, 2, 3, 0, 1};

   typedef struct packed {
      logic [15:0] grant;
      logic [3:0]  idx;
      logic        valid;
   } exp_t;

   exp_t q5[$];
   exp_t q4[$];

   int checks = 0;
   int errors = 0;

   bit m_lk [2];
   int m_pt [2];
   int m_g  [2];
   bit m_known = 1'b0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(input logic [15:0] r, input int p, input int n);
      for (int k = 0; k < n; k++) begin
         int j;
         j = (p + k) % n;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_step(input int d, input logic [15:0] r, input logic [15:0] t,
                             input logic rdy, input logic rst, output exp_t e);
      int n, w;
      bit xf, rel;
      n = (d == 0) ? 5 : 4;
      if (rst) begin
         m_lk[d] = 1'b0; m_pt[d] = 0; m_g[d] = 0;
      end else if (!m_lk[d]) begin
         w = winner(r, m_pt[d], n);
         if (w >= 0) begin m_lk[d] = 1'b1; m_g[d] = w; end
      end else begin
         xf  = r[m_g[d]] && rdy;
         rel = xf && (LOCK_MODE ? t[m_g[d]] : 1'b1);
         if (rel || (!LOCK_MODE && !r[m_g[d]])) begin
            if (rel) m_pt[d] = (m_g[d] + 1) % n;
            w = winner(r, m_pt[d], n);
            if (w >= 0) m_g[d] = w;
            else begin m_lk[d] = 1'b0; m_g[d] = 0; end
         end
      end
      e.valid = m_lk[d];
      e.grant = m_lk[d] ? (16'h1 << m_g[d]) : 16'h0;
      e.idx   = m_lk[d] ? 4'(m_g[d]) : 4'h0;
   endtask

   task automatic set5(input logic [4:0] r, input logic [4:0] t, input logic rdy);
      req5 = r; tail5 = t; ready5 = rdy;
   endtask

   task automatic set4(input logic [3:0] r, input logic [3:0] t, input logic rdy);
      req4 = r; tail4 = t; ready4 = rdy;
   endtask

   // One clock cycle: check xfer mid-cycle, predict, advance, compare.
   task automatic tick();
      exp_t e;
      bit   mx;
      @(negedge clk);
      if (m_known) begin
         mx = m_lk[0] && req5[m_g[0]] && ready5;
         check("xfer5", 16'(x5), 16'(mx));
         mx = m_lk[1] && req4[m_g[1]] && ready4;
         check("xfer4", 16'(x4), 16'(mx));
      end
      model_step(0, 16'(req5), 16'(tail5), ready5, reset, e);
      q5.push_back(e);
      model_step(1, 16'(req4), 16'(tail4), ready4, reset, e);
      q4.push_back(e);
      m_known = 1'b1;
      @(posedge clk);
      #1;
      e = q5.pop_front();
      check("grant5", 16'(g5), e.grant);
      check("idx5",   16'(idx5), 16'(e.idx));
      check("valid5", 16'(v5), 16'(e.valid));
      e = q4.pop_front();
      check("grant4", 16'(g4), e.grant);
      check("idx4",   16'(idx4), 16'(e.idx));
      check("valid4", 16'(v4), 16'(e.valid));
      $display("t=%0t req5=%b g5=%b x5=%b | req4=%b g4=%b x4=%b", $time, req5, g5, x5, req4, g4, x4);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      set5(5'b0, 5'b0, 1'b0);
      set4(4'b0, 4'b0, 1'b0);
      do_reset();
      check("rst_grant5", 16'(g5), 16'h0);
      check("rst_xfer5", 16'(x5), 16'h0);

      // Reset in mid-packet, N=5
      set5(5'b00110, 5'b00000, 1'b1);
      tick();
      check("a_grant_c1", 16'(g5), 16'h02);
      check("a_idx_c1", 16'(idx5), 16'h1);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("a_grant_c4", 16'(g5), 16'h0);
      tick();
      check("a_grant_c5", 16'(g5), 16'h02);
      set5(5'b0, 5'b0, 1'b0);
      do_reset();

      // Packet lock, N=5: input 0 sends a 3-flit packet, input 3 waits
      set5(5'b01001, 5'b00000, 1'b1);
      tick();
      check("b_head", 16'(g5), 16'h01);
      for (int k = 0; k < 3; k++) begin
         set5(5'b01001, (k == 2) ? 5'b00001 : 5'b00000, 1'b1);
         tick();
         check("b_seq", 16'(g5), 16'(exp_b[k]));
      end
      set5(5'b0, 5'b0, 1'b0);
      do_reset();

      // Wrap-around, N=4, every flit a tail
      set4(4'b1111, 4'b1111, 1'b1);
      tick();
      check("c_idx", 16'(idx4), 16'(exp_c[0]));
      for (int k = 1; k < 6; k++) begin
         tick();
         check("c_idx", 16'(idx4), 16'(exp_c[k]));
      end
      set4(4'b0, 4'b0, 1'b0);
      do_reset();

      // Backpressure, N=4: hold grant on input 2 while ready is low
      set4(4'b0100, 4'b0100, 1'b0);
      tick();
      check("d_grant", 16'(g4), 16'h4);
      for (int k = 0; k < 5; k++) begin
         check("d_xfer_low", 16'(x4), 16'h0);
         tick();
         check("d_hold", 16'(g4), 16'h4);
      end
      set4(4'b0101, 4'b0100, 1'b1);
      #1;
      check("d_xfer_high", 16'(x4), 16'h1);
      tick();
      check("d_release", 16'(g4), 16'h1);
      set4(4'b0, 4'b0, 1'b0);
      do_reset();

      // Idle gap, N=4
      set4(4'b1000, 4'b1000, 1'b1);
      tick();
      check("e_t1", 16'(g4), 16'(exp_e[0]));
      set4(4'b0000, 4'b0000, 1'b1);
      tick();
      check("e_t2", 16'(g4), 16'(exp_e[1]));
      tick();
      check("e_t3", 16'(g4), 16'(exp_e[2]));
      set4(4'b0001, 4'b0001, 1'b1);
      tick();
      check("e_t4", 16'(g4), 16'(exp_e[3]));
      set4(4'b0, 4'b0, 1'b0);
      do_reset();

      // Two requesters, never a tail; then input 0 withdraws while granted
      set4(4'b0011, 4'b0000, 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("f_alt", 16'(g4), 16'(exp_f[k]));
      end
      set4(4'b0010, 4'b0000, 1'b1);
      tick();
      check("f_withdraw", 16'(g4), 16'(exp_f[5]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
